// File: rtl/adder_arb_pkg.sv
// Shared defaults and types for the adder arbiter slice.
package adder_arb_pkg;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DW      = 10;
  localparam int DEF_MAX_OUT = 4;
  localparam int TAG_W       = $clog2(DEF_N_REQ);

  typedef logic [DEF_DW:0] result_t;
endpackage

// File: rtl/adder_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each in-flight add.
module adder_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one enabled adder; results are routed back to
// the issuing requester through an in-order tag FIFO.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DW      = DEF_DW,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*DW-1:0]   i_a,
  input  logic [N_REQ*DW-1:0]   i_b,
  input  logic [N_REQ-1:0]      i_cin,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [DW:0]           o_rsp_result,
  output logic                  o_add_enable,
  output logic [DW-1:0]         o_add_a,
  output logic [DW-1:0]         o_add_b,
  output logic                  o_add_cin,
  input  logic                  i_add_valid,
  input  logic [DW:0]           i_add_result,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam int TW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT) + 1;

  logic [TW-1:0] rr_ptr, win_idx, idx, head;
  logic          found, transfer, pop;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] out_cnt;

  // Scan from rr_ptr upward with wrap; first active request wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = TW'((int'(rr_ptr) + i) % N_REQ);
      if (!found && i_req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (found && !fifo_full) o_gnt[win_idx] = 1'b1;
  end

  assign transfer = found & ~fifo_full;
  assign pop      = i_add_valid & ~fifo_empty;
  assign o_busy   = (out_cnt != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr       <= '0;
      o_add_enable <= 1'b0;
      o_add_a      <= '0;
      o_add_b      <= '0;
      o_add_cin    <= 1'b0;
    end else begin
      o_add_enable <= transfer;
      if (transfer) begin
        rr_ptr    <= (win_idx == TW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        o_add_a   <= i_a[win_idx*DW +: DW];
        o_add_b   <= i_b[win_idx*DW +: DW];
        o_add_cin <= i_cin[win_idx];
      end
    end
  end

  // A valid with nothing in flight is unowned: flag it, never route it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_valid  <= '0;
      o_rsp_result <= '0;
      o_err        <= 1'b0;
    end else begin
      o_rsp_valid <= '0;
      if (i_add_valid) begin
        if (!fifo_empty) begin
          o_rsp_valid[head] <= 1'b1;
          o_rsp_result      <= i_add_result;
        end else begin
          o_err <= 1'b1;
        end
      end
    end
  end

  adder_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TW)
  ) u_tag_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (transfer),
    .pop   (pop),
    .din   (win_idx),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (out_cnt)
  );
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: one arbiter on a 1-cycle adder model, one with two
// credits on a 4-cycle adder model.
module tb_adder_arbiter;
  localparam int N  = 4;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [N-1:0]    req, cin;
  logic [N*DW-1:0] a_bus, b_bus;
  logic [N-1:0]    gnt, rsp_valid;
  logic [DW:0]     rsp_result;
  logic            add_en, add_cin, add_valid, busy, err;
  logic [DW-1:0]   add_a, add_b;
  logic [DW:0]     add_result;
  logic            mv, inj;
  logic [DW:0]     mres;

  logic [N-1:0]    req2, cin2;
  logic [N*DW-1:0] a2_bus, b2_bus;
  logic [N-1:0]    gnt2, rsp_valid2;
  logic [DW:0]     rsp_result2;
  logic            add_en2, add_cin2, add_valid2, busy2, err2;
  logic [DW-1:0]   add_a2, add_b2;
  logic [DW:0]     add_result2;
  logic [3:0]      sv2;

  adder_arbiter #(.N_REQ(N), .DW(DW), .MAX_OUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_a(a_bus), .i_b(b_bus), .i_cin(cin),
    .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_result(rsp_result),
    .o_add_enable(add_en), .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_valid(add_valid), .i_add_result(add_result), .o_busy(busy), .o_err(err)
  );

  adder_arbiter #(.N_REQ(N), .DW(DW), .MAX_OUT(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_a(a2_bus), .i_b(b2_bus), .i_cin(cin2),
    .o_gnt(gnt2), .o_rsp_valid(rsp_valid2), .o_rsp_result(rsp_result2),
    .o_add_enable(add_en2), .o_add_a(add_a2), .o_add_b(add_b2), .o_add_cin(add_cin2),
    .i_add_valid(add_valid2), .i_add_result(add_result2), .o_busy(busy2), .o_err(err2)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv   <= 1'b0;
      mres <= '0;
    end else begin
      mv   <= add_en;
      mres <= {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    end
  end
  assign add_valid  = mv | inj;
  assign add_result = mres;

  always @(posedge clk or posedge rst) begin
    if (rst) sv2 <= '0;
    else     sv2 <= {sv2[2:0], add_en2};
  end
  assign add_valid2  = sv2[3];
  assign add_result2 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req2 = '0; inj = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] exp2 [7];

  initial begin
    rst = 1'b1; req = '0; cin = '0; a_bus = '0; b_bus = '0; inj = 1'b0;
    req2 = '0; cin2 = '0; a2_bus = '0; b2_bus = '0;
    exp2 = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_en", 32'(add_en), 0);
    chk("rst_a", 32'(add_a), 0);
    chk("rst_b", 32'(add_b), 0);
    chk("rst_cin", 32'(add_cin), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // single request: 28 + 33
    @(negedge clk);
    req = 4'b0001; a_bus[0 +: DW] = 28; b_bus[0 +: DW] = 33; cin = '0;
    #1 chk("t1_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = '0;
    #1;
    chk("t1_en", 32'(add_en), 1);
    chk("t1_a", 32'(add_a), 28);
    chk("t1_b", 32'(add_b), 33);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk);
    #1 chk("t1_rsp_early", 32'(rsp_valid), 0);
    @(negedge clk);
    #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_result", 32'(rsp_result), 61);
    chk("t1_busy_idle", 32'(busy), 0);
    @(negedge clk);
    #1 chk("t1_rsp_pulse", 32'(rsp_valid), 0);

    // contention between requesters 0 and 2
    do_reset();
    req = 4'b0101;
    a_bus[0 +: DW] = 5;  b_bus[0 +: DW] = 6;
    a_bus[2*DW +: DW] = 81; b_bus[2*DW +: DW] = 17;
    #1 chk("t2_gnt0", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'b0100;
    #1;
    chk("t2_gnt2", 32'(gnt), 32'h4);
    chk("t2_a0", 32'(add_a), 5);
    @(negedge clk);
    req = '0;
    #1;
    chk("t2_gnt_none", 32'(gnt), 0);
    chk("t2_en2", 32'(add_en), 1);
    chk("t2_a2", 32'(add_a), 81);
    chk("t2_b2", 32'(add_b), 17);
    @(negedge clk);
    #1;
    chk("t2_rsp0", 32'(rsp_valid), 32'h1);
    chk("t2_res0", 32'(rsp_result), 11);
    @(negedge clk);
    #1;
    chk("t2_rsp2", 32'(rsp_valid), 32'h4);
    chk("t2_res2", 32'(rsp_result), 98);

    // fairness with all four held
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
      @(negedge clk);
    end
    req = '0;
    repeat (4) @(negedge clk);
    #1 chk("t3_busy_idle", 32'(busy), 0);

    // credit stall: two credits, 4-cycle adder
    do_reset();
    req2 = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      #1 chk($sformatf("t4_gnt%0d", k), 32'(gnt2), 32'(exp2[k]));
      if (k == 3) chk("t4_busy", 32'(busy2), 1);
      @(negedge clk);
    end
    req2 = '0;
    repeat (10) @(negedge clk);
    #1 chk("t4_err", 32'(err2), 0);

    // carry out: 1023 + 1 + 1
    do_reset();
    req = 4'b0001; a_bus[0 +: DW] = 1023; b_bus[0 +: DW] = 1; cin = 4'b0001;
    #1 chk("t5_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = '0;
    #1 chk("t5_cin", 32'(add_cin), 1);
    repeat (2) @(negedge clk);
    #1;
    chk("t5_rsp", 32'(rsp_valid), 32'h1);
    chk("t5_res", 32'(rsp_result), 32'h401);

    // unowned valid sets sticky error; reset mid-flight clears everything
    do_reset();
    cin = '0;
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1;
    chk("t6_err", 32'(err), 1);
    chk("t6_no_rsp", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    #1 chk("t6_err_sticky", 32'(err), 1);
    @(negedge clk);
    req = 4'b0001; a_bus[0 +: DW] = 3; b_bus[0 +: DW] = 4;
    #1 chk("t6_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = '0;
    #1;
    chk("t6_en", 32'(add_en), 1);
    chk("t6_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_en", 32'(add_en), 0);
    chk("t6_rst_a", 32'(add_a), 0);
    chk("t6_rst_b", 32'(add_b), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_post_rsp", 32'(rsp_valid), 0);
    chk("t6_post_err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
